// File: rtl/mccoy_pkg.sv
// Shared definitions for the McCoy core: sequencer state encoding and default widths.
package mccoy_pkg;

  localparam int PC_W_DEF = 8;
  localparam int X_W_DEF  = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } seq_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC resolution: relative target for jal/ja/taken bez, else PC+1.
module pc_next_sel #(
  parameter int PC_W = 8,
  parameter int X_W  = 6
) (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] alu_out,
  input  logic [X_W-1:0]  x8,
  input  logic            ja,
  input  logic            bez,
  input  logic            jal,
  output logic [PC_W-1:0] next_pc,
  output logic            taken
);

  // jal, ja and taken bez all share the same relative target, so only the
  // taken decision needs priority; halt is resolved by the caller.
  assign taken   = jal || ja || (bez && (x8 == '0));
  assign next_pc = taken ? (pc + alu_out) : (pc + PC_W'(1));

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer owning the program counter for the McCoy core.
// Optional jump-and-link support (jal input, link output) is enabled by PCSEQ_LINK_EN.
module pc_sequencer
  import mccoy_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int X_W  = X_W_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic            ja,
  input  logic            bez,
  input  logic [X_W-1:0]  x8,
  input  logic [PC_W-1:0] alu_out,
  input  logic            halt,
`ifdef PCSEQ_LINK_EN
  input  logic            jal,
  output logic [PC_W-1:0] link,
`endif
  output logic [PC_W-1:0] pc,
  output logic            exec_en,
  output logic [1:0]      state
);

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            ready_q, exec_en_q;
  logic [PC_W-1:0] next_pc;
  logic            taken;
  logic            jal_sel;

`ifdef PCSEQ_LINK_EN
  logic [PC_W-1:0] link_q, link_d;
  assign jal_sel = jal;
`else
  assign jal_sel = 1'b0;
`endif

  pc_next_sel #(.PC_W(PC_W), .X_W(X_W)) u_next_sel (
    .pc      (pc_q),
    .alu_out (alu_out),
    .x8      (x8),
    .ja      (ja),
    .bez     (bez),
    .jal     (jal_sel),
    .next_pc (next_pc),
    .taken   (taken)
  );

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PCSEQ_LINK_EN
    link_d  = link_q;
`endif
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if (instr_valid && ready_q) state_d = EXEC;
      EXEC: begin
        if (halt) begin
          state_d = HALTED;
        end else begin
          state_d = FETCH;
          pc_d    = next_pc;
`ifdef PCSEQ_LINK_EN
          if (jal) link_d = pc_q + PC_W'(1);
`endif
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and strobe are decoded from the next state so they are registered
  // and line up exactly with the state they belong to.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      ready_q   <= 1'b0;
      exec_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ready_q   <= (state_d == FETCH);
      exec_en_q <= (state_d == EXEC);
    end
  end

`ifdef PCSEQ_LINK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) link_q <= '0;
    else          link_q <= link_d;
  end
  assign link = link_q;
`endif

  assign pc          = pc_q;
  assign instr_ready = ready_q;
  assign exec_en     = exec_en_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; covers link when PCSEQ_LINK_EN is defined.
`timescale 1ns/1ps
module tb_pc_sequencer;

  localparam int PC_W = 8;
  localparam int X_W  = 6;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            instr_valid;
  logic            instr_ready;
  logic            ja, bez, halt;
  logic [X_W-1:0]  x8;
  logic [PC_W-1:0] alu_out;
  logic [PC_W-1:0] pc;
  logic            exec_en;
  logic [1:0]      state;
`ifdef PCSEQ_LINK_EN
  logic            jal;
  logic [PC_W-1:0] link;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.PC_W(PC_W), .X_W(X_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .ja          (ja),
    .bez         (bez),
    .x8          (x8),
    .alu_out     (alu_out),
    .halt        (halt),
`ifdef PCSEQ_LINK_EN
    .jal         (jal),
    .link        (link),
`endif
    .pc          (pc),
    .exec_en     (exec_en),
    .state       (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_decode();
    ja = 1'b0; bez = 1'b0; halt = 1'b0; x8 = '0; alu_out = '0;
`ifdef PCSEQ_LINK_EN
    jal = 1'b0;
`endif
  endtask

  // Entered at a negedge while in FETCH; leaves at the negedge after the EXEC cycle.
  task automatic run_instr(input string tag, input logic i_ja, input logic i_bez,
                           input logic [X_W-1:0] i_x8, input logic [PC_W-1:0] i_alu,
                           input logic i_halt, input logic i_jal,
                           input logic [PC_W-1:0] exp_pc);
    instr_valid = 1'b1;
    @(negedge clk);
    check({tag, ".exec_en"}, 32'(exec_en), 32'd1);
    check({tag, ".ready_in_exec"}, 32'(instr_ready), 32'd0);
    ja = i_ja; bez = i_bez; x8 = i_x8; alu_out = i_alu; halt = i_halt;
`ifdef PCSEQ_LINK_EN
    jal = i_jal;
`else
    if (i_jal) check({tag, ".jal_unsupported"}, 32'd1, 32'd0);
`endif
    @(negedge clk);
    clear_decode();
    instr_valid = 1'b0;
    check({tag, ".pc"}, 32'(pc), 32'(exp_pc));
    check({tag, ".state"}, 32'(state), i_halt ? 32'd3 : 32'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    instr_valid = 1'b1;
    clear_decode();
    repeat (2) @(negedge clk);
    check("rst.state", 32'(state), 32'd0);
    check("rst.pc", 32'(pc), 32'd0);
    check("rst.ready", 32'(instr_ready), 32'd0);
    check("rst.exec_en", 32'(exec_en), 32'd0);
`ifdef PCSEQ_LINK_EN
    check("rst.link", 32'(link), 32'd0);
`endif

    // 1: IDLE one cycle, FETCH, EXEC at pc 0, then pc 1
    reset_n = 1'b1;
    @(negedge clk);
    check("t1.fetch_state", 32'(state), 32'd1);
    check("t1.fetch_ready", 32'(instr_ready), 32'd1);
    @(negedge clk);
    check("t1.exec_state", 32'(state), 32'd2);
    check("t1.exec_en", 32'(exec_en), 32'd1);
    check("t1.exec_pc", 32'(pc), 32'd0);
    @(negedge clk);
    instr_valid = 1'b0;
    check("t1.pc_after", 32'(pc), 32'd1);
    check("t1.state_after", 32'(state), 32'd1);

    // 2: bez taken / not taken at pc 3
    run_instr("seq_2", 0, 0, 6'd0, 8'd0, 0, 0, 8'd2);
    run_instr("seq_3", 0, 0, 6'd0, 8'd0, 0, 0, 8'd3);
    run_instr("bez_taken", 0, 1, 6'd0, 8'd5, 0, 0, 8'd8);
    run_instr("ja_back3", 1, 0, 6'd0, 8'hFB, 0, 0, 8'd3);
    run_instr("bez_untaken", 0, 1, 6'd1, 8'd5, 0, 0, 8'd4);

    // 3: ja beats bez, negative offset
    run_instr("ja_to2", 1, 0, 6'd0, 8'hFE, 0, 0, 8'd2);
    run_instr("ja_over_bez", 1, 1, 6'd7, 8'hFE, 0, 0, 8'd0);

    // 4: wrap, then loader stall
    run_instr("ja_to_ff", 1, 0, 6'd0, 8'hFF, 0, 0, 8'hFF);
    run_instr("wrap", 0, 0, 6'd0, 8'd0, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall.state", 32'(state), 32'd1);
      check("stall.pc", 32'(pc), 32'd0);
      check("stall.exec_en", 32'(exec_en), 32'd0);
    end

`ifdef PCSEQ_LINK_EN
    // 6: jump-and-link from pc 4
    run_instr("ja_to4", 1, 0, 6'd0, 8'd4, 0, 0, 8'd4);
    run_instr("jal", 0, 0, 6'd0, 8'd16, 0, 1, 8'd20);
    check("jal.link", 32'(link), 32'd5);
    run_instr("ja_to9", 1, 0, 6'd0, 8'hF5, 0, 0, 8'd9);
`else
    run_instr("ja_to9", 1, 0, 6'd0, 8'd9, 0, 0, 8'd9);
`endif

    // 5: halt beats ja, then frozen with loader pushing
    run_instr("halt", 1, 0, 6'd0, 8'd3, 1, 0, 8'd9);
    instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halted.state", 32'(state), 32'd3);
      check("halted.pc", 32'(pc), 32'd9);
      check("halted.exec_en", 32'(exec_en), 32'd0);
      check("halted.ready", 32'(instr_ready), 32'd0);
    end

    // reset mid-EXEC aborts with no pc update
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    run_instr("r_ja5", 1, 0, 6'd0, 8'd5, 0, 0, 8'd5);
    instr_valid = 1'b1;
    @(negedge clk);
    check("abort.in_exec", 32'(state), 32'd2);
    ja = 1'b1; alu_out = 8'd7;
    reset_n = 1'b0;
    #1;
    check("abort.pc", 32'(pc), 32'd0);
    check("abort.state", 32'(state), 32'd0);
    check("abort.exec_en", 32'(exec_en), 32'd0);
    @(negedge clk);
    clear_decode();
    check("abort.held_pc", 32'(pc), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rerun.fetch", 32'(state), 32'd1);
    instr_valid = 1'b0;
    run_instr("rerun.seq", 0, 0, 6'd0, 8'd0, 0, 0, 8'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
